ct_mmu_dutlb_refill_ctrl: RTL

CT_MMU_DUTLB_REFILL_CTRL -- requirements
Module: ct_mmu_dutlb_refill_ctrl

---
 rtl/ct_mmu_dutlb_refill_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ct_mmu_dutlb_refill_ctrl.sv
// uTLB refill controller: on a uTLB miss, requests a translation from the jTLB,
// waits for the response and writes it into a victim uTLB entry. Clears and
// matching invalidates abort an in-flight refill; an aborted request that the
// jTLB has already accepted is drained in the discard state.
module ct_mmu_dutlb_refill_ctrl #(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned VPN_WIDTH = 27,
  parameter int unsigned PPN_WIDTH = 28,
  parameter int unsigned FLG_WIDTH = 14
) (
  input  logic                 utlb_entry_clk,
  input  logic                 cpurst_b,
  input  logic                 utlb_miss_vld,
  input  logic [VPN_WIDTH-1:0] utlb_miss_vpn,
  input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
  input  logic                 jtlb_utlb_grant,
  input  logic                 jtlb_utlb_refill_vld,
  input  logic [PPN_WIDTH-1:0] jtlb_utlb_ppn,
  input  logic [FLG_WIDTH-1:0] jtlb_utlb_flg,
  input  logic                 jtlb_utlb_fault,
  input  logic                 regs_utlb_clr,
  input  logic                 tlboper_utlb_clr,
  input  logic                 tlboper_utlb_inv_va_req,
  input  logic [VPN_WIDTH-1:0] lsu_mmu_tlb_va,
  output logic                 utlb_jtlb_req,
  output logic [VPN_WIDTH-1:0] utlb_jtlb_vpn,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
  output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
  output logic [FLG_WIDTH-1:0] utlb_upd_flg,
  output logic                 utlb_refill_fault,
  output logic                 utlb_refill_busy
);

  localparam int unsigned PTR_WIDTH = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StUpd,
    StDisc
  } state_e;

  state_e                 state_q;
  logic [VPN_WIDTH-1:0]   vpn_q;
  logic [PTR_WIDTH-1:0]   rr_ptr_q;
  logic                   req_q;
  logic [ENTRY_NUM-1:0]   upd_q;
  logic [VPN_WIDTH-1:0]   upd_vpn_q;
  logic [PPN_WIDTH-1:0]   upd_ppn_q;
  logic [FLG_WIDTH-1:0]   upd_flg_q;
  logic                   fault_q;

  logic                   abort;
  logic [PTR_WIDTH-1:0]   victim_idx;
  logic                   victim_free;
  logic [ENTRY_NUM-1:0]   victim_onehot;
  logic [PTR_WIDTH-1:0]   rr_ptr_nxt;

  // Only the low VA byte takes part in the invalidate match.
  logic unused_va;
  assign unused_va = ^lsu_mmu_tlb_va[VPN_WIDTH-1:8];

  assign abort = regs_utlb_clr | tlboper_utlb_clr |
                 (tlboper_utlb_inv_va_req && (lsu_mmu_tlb_va[7:0] == vpn_q[7:0]));

  // Victim: lowest-index invalid entry, otherwise the round-robin pointer.
  always_comb begin
    victim_idx  = rr_ptr_q;
    victim_free = 1'b0;
    for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--) begin
      if (!utlb_entry_vld[i]) begin
        victim_idx  = PTR_WIDTH'(i);
        victim_free = 1'b1;
      end
    end
  end

  // One-hot decode of the victim and next round-robin pointer.
  always_comb begin
    victim_onehot             = '0;
    victim_onehot[victim_idx] = 1'b1;
    rr_ptr_nxt = (rr_ptr_q == PTR_WIDTH'(ENTRY_NUM - 1)) ? '0 : rr_ptr_q + PTR_WIDTH'(1);
  end

  // Refill FSM with registered outputs; upd and fault are single-cycle pulses.
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= StIdle;
      vpn_q     <= '0;
      rr_ptr_q  <= '0;
      req_q     <= 1'b0;
      upd_q     <= '0;
      upd_vpn_q <= '0;
      upd_ppn_q <= '0;
      upd_flg_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      upd_q   <= '0;
      fault_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (utlb_miss_vld) begin
            vpn_q   <= utlb_miss_vpn;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (abort) begin
            req_q <= 1'b0;
            // A granted request will still be answered, so it must be drained.
            state_q <= jtlb_utlb_grant ? StDisc : StIdle;
          end else if (jtlb_utlb_grant) begin
            req_q   <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (abort) begin
            // Response in the same cycle is consumed and dropped.
            state_q <= jtlb_utlb_refill_vld ? StIdle : StDisc;
          end else if (jtlb_utlb_refill_vld) begin
            if (jtlb_utlb_fault) begin
              fault_q <= 1'b1;
              state_q <= StIdle;
            end else begin
              upd_q     <= victim_onehot;
              upd_vpn_q <= vpn_q;
              upd_ppn_q <= jtlb_utlb_ppn;
              upd_flg_q <= jtlb_utlb_flg;
              if (!victim_free) begin
                rr_ptr_q <= rr_ptr_nxt;
              end
              state_q <= StUpd;
            end
          end
        end
        StUpd: begin
          state_q <= StIdle;
        end
        StDisc: begin
          if (jtlb_utlb_refill_vld) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign utlb_jtlb_req     = req_q;
  assign utlb_jtlb_vpn     = vpn_q;
  assign utlb_entry_upd    = upd_q;
  assign utlb_upd_vpn      = upd_vpn_q;
  assign utlb_upd_ppn      = upd_ppn_q;
  assign utlb_upd_flg      = upd_flg_q;
  assign utlb_refill_fault = fault_q;
  assign utlb_refill_busy  = (state_q != StIdle);

endmodule
